// File: rtl/alu_pkg.sv
// Shared constants for the shared-ALU scheduler: default widths, opcodes, FSM states.
package alu_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_OPW   = 3;

    localparam logic [DEF_OPW-1:0] OP_ADD = 3'b000;
    localparam logic [DEF_OPW-1:0] OP_SUB = 3'b001;
    localparam logic [DEF_OPW-1:0] OP_AND = 3'b010;
    localparam logic [DEF_OPW-1:0] OP_OR  = 3'b011;
    localparam logic [DEF_OPW-1:0] OP_XOR = 3'b100;
    localparam logic [DEF_OPW-1:0] OP_NOT = 3'b101;
    localparam logic [DEF_OPW-1:0] OP_SHL = 3'b110;
    localparam logic [DEF_OPW-1:0] OP_SHR = 3'b111;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_EXEC = 2'd1;
    localparam state_t S_RESP = 2'd2;

endpackage

// File: rtl/alu_core.sv
// Combinational 8-op ALU: result, carry/borrow/shift-out and zero flag.
// Zero latency; no handshake, fed from the scheduler's operand registers.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPW   = DEF_OPW
) (
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             zero
);

    always_comb begin
        y     = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: {carry, y} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                y     = a - b;
                carry = (a < b);
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_SHL: begin
                y     = {a[WIDTH-2:0], 1'b0};
                carry = a[WIDTH-1];
            end
            OP_SHR: begin
                y     = {1'b0, a[WIDTH-1:1]};
                carry = a[0];
            end
            default: ;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin two-requester scheduler around one shared ALU; result registered, rsp_valid two cycles after accept.
// Backpressure: result held in RESP until rsp_ready; req_ready stays low in EXEC/RESP so new requests wait.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPW   = DEF_OPW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero
);

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             id_q, id_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             gnt;
    logic [WIDTH-1:0] alu_y;
    logic             alu_carry, alu_zero;

    alu_core #(.WIDTH(WIDTH), .OPW(OPW)) u_alu (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
        .y     (alu_y),
        .carry (alu_carry),
        .zero  (alu_zero)
    );

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_zero_d  = rsp_zero_q;
        req_ready   = 2'b00;
        // Lone requester wins outright; the pointer only breaks ties.
        gnt         = (req_valid == 2'b11) ? prio_q : req_valid[1];
        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    req_ready = gnt ? 2'b10 : 2'b01;
                    op_d      = gnt ? req1_op : req0_op;
                    a_d       = gnt ? req1_a  : req0_a;
                    b_d       = gnt ? req1_b  : req0_b;
                    id_d      = gnt;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_data_d  = alu_y;
                rsp_carry_d = alu_carry;
                rsp_zero_d  = alu_zero;
                rsp_id_d    = id_q;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    prio_d  = ~rsp_id_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            prio_q      <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomized and directed bench for alu_share_ctrl against an arithmetic reference model.
module tb_alu_share_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_ready;
    logic [2:0] req0_op = 3'd0, req1_op = 3'd0;
    logic [7:0] req0_a = 8'd0, req0_b = 8'd0, req1_a = 8'd0, req1_b = 8'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic       rsp_id;
    logic [7:0] rsp_data;
    logic       rsp_carry, rsp_zero;

    int   total = 0;
    int   bad = 0;
    logic m_prio = 1'b0;

    alu_share_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_op   (req0_op),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_op   (req1_op),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference ALU from plain unsigned arithmetic.
    function automatic void ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] y, output logic c);
        int s;
        s = 0;
        c = 1'b0;
        case (op)
            3'd0: begin s = int'(a) + int'(b); c = (s >= 256); end
            3'd1: begin s = (int'(a) - int'(b) + 256) % 256; c = (a < b); end
            3'd2: s = int'(a & b);
            3'd3: s = int'(a | b);
            3'd4: s = int'(a ^ b);
            3'd5: s = 255 - int'(a);
            3'd6: begin s = int'(a) * 2; c = (s >= 256); end
            default: begin s = int'(a) / 2; c = (a % 2 == 1); end
        endcase
        y = 8'(s % 256);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero} !== 13'd0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b id=%b data=%h c=%b z=%b, want all zero",
                     req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_prio = 1'b0;
    endtask

    task automatic test_single_op(input logic r, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] ey;
        logic       ec;
        logic [1:0] eg;
        ref_alu(op, a, b, ey, ec);
        eg = r ? 2'b10 : 2'b01;
        @(posedge clk); #1;
        if (r) begin req1_op = op; req1_a = a; req1_b = b; end
        else   begin req0_op = op; req0_a = a; req0_b = b; end
        req_valid = eg;
        @(negedge clk);
        total++;
        if (req_ready !== eg) begin
            bad++;
            $display("FAIL single_grant op=%0d: got req_ready=%b want %b", op, req_ready, eg);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        total++;
        if ({req_ready, rsp_valid} !== 3'b000) begin
            bad++;
            $display("FAIL single_exec op=%0d: got rdy=%b vld=%b want 00/0", op, req_ready, rsp_valid);
        end
        @(negedge clk);
        total++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero} !== {1'b1, r, ey, ec, (ey == 8'd0)}) begin
            bad++;
            $display("FAIL single_rsp op=%0d: got vld=%b id=%b data=%h c=%b z=%b want 1 %b %h %b %b",
                     op, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero, r, ey, ec, (ey == 8'd0));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_drop op=%0d: got rsp_valid=%b want 0", op, rsp_valid);
        end
        m_prio = ~r;
    endtask

    task automatic test_contention();
        logic exp_id;
        int   nresp;
        exp_id = m_prio;
        nresp = 0;
        @(posedge clk); #1;
        req0_op = 3'd0; req0_a = 8'h01; req0_b = 8'h02;
        req1_op = 3'd2; req1_a = 8'hF0; req1_b = 8'h3C;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && nresp < 6; cyc++) begin
            @(negedge clk);
            total++;
            if (req_ready === 2'b11) begin
                bad++;
                $display("FAIL contention_onehot: got req_ready=%b want at most one bit", req_ready);
            end
            if (rsp_valid) begin
                total++;
                if ({rsp_id, rsp_data} !== {exp_id, (exp_id ? 8'h30 : 8'h03)}) begin
                    bad++;
                    $display("FAIL contention_rsp #%0d: got id=%b data=%h want id=%b data=%h",
                             nresp, rsp_id, rsp_data, exp_id, (exp_id ? 8'h30 : 8'h03));
                end
                exp_id = ~exp_id;
                nresp++;
                if (nresp == 6) req_valid = 2'b00;
            end
        end
        total++;
        if (nresp != 6) begin
            bad++;
            $display("FAIL contention_count: got %0d responses want 6", nresp);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 2'b00;
        m_prio = exp_id;
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        req1_op = 3'd3; req1_a = 8'h0F; req1_b = 8'hA0;
        req_valid = 2'b10;
        @(posedge clk); #1;
        req0_op = 3'd4; req0_a = 8'h3C; req0_b = 8'h3C;
        req_valid = 2'b01;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero, req_ready} !== {1'b1, 1'b1, 8'hAF, 1'b0, 1'b0, 2'b00}) begin
                bad++;
                $display("FAIL backpressure_hold cyc%0d: got vld=%b id=%b data=%h c=%b z=%b rdy=%b want 1 1 af 0 0 00",
                         i, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({rsp_valid, req_ready} !== 3'b001) begin
            bad++;
            $display("FAIL backpressure_release: got vld=%b rdy=%b want 0 01", rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL backpressure_waiter: got vld=%b id=%b data=%h c=%b z=%b want 1 0 00 0 1",
                     rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        m_prio = 1'b1;
    endtask

    task automatic test_reset_midop();
        @(posedge clk); #1;
        req0_op = 3'd0; req0_a = 8'h12; req0_b = 8'h34;
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero} !== 13'd0) begin
            bad++;
            $display("FAIL midop_reset: got rdy=%b vld=%b id=%b data=%h c=%b z=%b want all zero",
                     req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_prio = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL midop_ghost cyc%0d: got rsp_valid=%b want 0", i, rsp_valid);
            end
        end
        @(posedge clk); #1;
        req0_op = 3'd7; req0_a = 8'h81; req0_b = 8'h00;
        req1_op = 3'd5; req1_a = 8'h0F; req1_b = 8'h00;
        req_valid = 2'b11;
        @(negedge clk);
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("FAIL midop_first_grant: got req_ready=%b want 01", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero} !== {1'b1, 1'b0, 8'h40, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL midop_rsp: got vld=%b id=%b data=%h c=%b z=%b want 1 0 40 1 0",
                     rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        m_prio = 1'b1;
    endtask

    task automatic test_random(input int n);
        logic [1:0] mask;
        logic       g;
        logic [2:0] o0, o1, eo;
        logic [7:0] a0, b0, a1, b1, ea, eb, ey;
        logic       ec;
        int         k, d;
        for (int i = 0; i < n; i++) begin
            mask = 2'($urandom_range(1, 3));
            o0 = 3'($urandom); o1 = 3'($urandom);
            a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
            d = $urandom_range(0, 3);
            g = (mask == 2'b11) ? m_prio : mask[1];
            eo = g ? o1 : o0; ea = g ? a1 : a0; eb = g ? b1 : b0;
            ref_alu(eo, ea, eb, ey, ec);
            @(posedge clk); #1;
            req0_op = o0; req0_a = a0; req0_b = b0;
            req1_op = o1; req1_a = a1; req1_b = b1;
            req_valid = mask;
            @(negedge clk);
            total++;
            if (req_ready !== (g ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL rand_grant #%0d: got req_ready=%b want grant %b (mask %b)", i, req_ready, g, mask);
            end
            @(posedge clk); #1;
            req_valid = 2'b00;
            rsp_ready = 1'($urandom_range(0, 1));
            k = 0;
            while (!rsp_valid && k < 6) begin
                @(negedge clk);
                k++;
            end
            rsp_ready = 1'b0;
            total++;
            if (k != 2 || {rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero} !== {1'b1, g, ey, ec, (ey == 8'd0)}) begin
                bad++;
                $display("FAIL rand_rsp #%0d: got lat=%0d vld=%b id=%b data=%h c=%b z=%b want lat=2 1 %b %h %b %b",
                         i, k, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero, g, ey, ec, (ey == 8'd0));
            end
            for (int j = 0; j < d; j++) begin
                @(negedge clk);
                total++;
                if ({rsp_valid, rsp_data, req_ready} !== {1'b1, ey, 2'b00}) begin
                    bad++;
                    $display("FAIL rand_hold #%0d: got vld=%b data=%h rdy=%b want 1 %h 00",
                             i, rsp_valid, rsp_data, req_ready, ey);
                end
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            m_prio = ~g;
        end
    endtask

    initial begin
        test_reset();
        test_single_op(1'b0, 3'd4, 8'hAA, 8'h55);
        test_single_op(1'b0, 3'd0, 8'hFF, 8'h01);
        test_single_op(1'b1, 3'd1, 8'h10, 8'h20);
        test_single_op(1'b0, 3'd6, 8'h81, 8'h00);
        test_single_op(1'b1, 3'd7, 8'h01, 8'h00);
        test_contention();
        test_backpressure();
        test_reset_midop();
        test_random(40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
